// File: rtl/time_display_driver.sv
// Samples hour/min/sec once per display frame, converts each to BCD by repeated
// subtract-by-10, and scans the result onto an active-low 8-digit 7-seg display as HH.MM.SS.
module time_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [4:0] hour_in,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] DASH  = 4'hA;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [2:0] {IDLE, CAPTURE, CONV_H, CONV_M, CONV_S, COMMIT} state_t;

  state_t         state;
  logic [TW-1:0]  tick;
  logic [2:0]     idx;
  logic [2:0]     idx_nx;
  logic           wrap;
  logic           start;
  logic [5:0]     rem;
  logic [2:0]     tens;
  logic [5:0]     min_snap;
  logic [5:0]     sec_snap;
  logic           hour_ok;
  logic           min_ok;
  logic           sec_ok;
  logic [5:0][3:0] pend;
  logic [5:0][3:0] disp;
  logic [3:0]     cur;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      DASH:    decode = 7'b0111111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    wrap   = (tick == TW'(REFRESH_DIV - 1));
    idx_nx = idx;
    if (wrap) idx_nx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    start  = wrap && (idx == 3'd5);
    cur    = BLANK;
    case (idx_nx)
      3'd0:    cur = disp[0];
      3'd1:    cur = disp[1];
      3'd2:    cur = disp[2];
      3'd3:    cur = disp[3];
      3'd4:    cur = disp[4];
      3'd5:    cur = disp[5];
      default: cur = BLANK;
    endcase
  end

  // Outputs are registered from the next index so an, seg and dp move together.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tick <= '0;
      idx  <= 3'd0;
      an   <= 8'b1111_1110;
      seg  <= 7'b1000000;
      dp   <= 1'b1;
    end else begin
      tick <= wrap ? '0 : tick + TW'(1);
      idx  <= idx_nx;
      an   <= ~(8'b0000_0001 << idx_nx);
      seg  <= decode(cur);
      dp   <= !((idx_nx == 3'd2) || (idx_nx == 3'd4));
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= CAPTURE;
      rem      <= '0;
      tens     <= '0;
      min_snap <= '0;
      sec_snap <= '0;
      hour_ok  <= 1'b1;
      min_ok   <= 1'b1;
      sec_ok   <= 1'b1;
      pend     <= '0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= CAPTURE;
        CAPTURE: begin
          rem      <= {1'b0, hour_in};
          min_snap <= min_in;
          sec_snap <= sec_in;
          hour_ok  <= (hour_in <= 5'd23);
          min_ok   <= (min_in <= 6'd59);
          sec_ok   <= (sec_in <= 6'd59);
          tens     <= '0;
          state    <= CONV_H;
        end
        CONV_H: begin
          if (rem >= 6'd10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            pend[4] <= hour_ok ? rem[3:0] : DASH;
            pend[5] <= hour_ok ? {1'b0, tens} : DASH;
            rem     <= min_snap;
            tens    <= '0;
            state   <= CONV_M;
          end
        end
        CONV_M: begin
          if (rem >= 6'd10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            pend[2] <= min_ok ? rem[3:0] : DASH;
            pend[3] <= min_ok ? {1'b0, tens} : DASH;
            rem     <= sec_snap;
            tens    <= '0;
            state   <= CONV_S;
          end
        end
        CONV_S: begin
          if (rem >= 6'd10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            pend[0] <= sec_ok ? rem[3:0] : DASH;
            pend[1] <= sec_ok ? {1'b0, tens} : DASH;
            tens    <= '0;
            state   <= COMMIT;
          end
        end
        COMMIT: begin
          // All six digits change on one edge so a frame never shows a half-updated time.
          disp  <= pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
// Table- and sequence-driven bench for time_display_driver with REFRESH_DIV=4 (24-cycle frames).
module tb_time_display_driver;

  localparam int DIV  = 4;
  localparam int FR   = 6 * DIV;
  localparam int DASH = 10;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] hour_in = '0;
  logic [5:0] min_in = '0;
  logic [5:0] sec_in = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int h;
    int m;
    int s;
    int d[6];
  } vec_t;

  typedef struct {
    int         n;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[6];

  time_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .hour_in(hour_in),
    .min_in(min_in),
    .sec_in(sec_in),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Cycles since reset deasserted: after the n-th rising edge with reset low, cyc == n.
  always @(posedge clk_100MHz) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       seg_of = 7'b1000000;
      1:       seg_of = 7'b1111001;
      2:       seg_of = 7'b0100100;
      3:       seg_of = 7'b0110000;
      4:       seg_of = 7'b0011001;
      5:       seg_of = 7'b0010010;
      6:       seg_of = 7'b0000010;
      7:       seg_of = 7'b1111000;
      8:       seg_of = 7'b0000000;
      9:       seg_of = 7'b0010000;
      DASH:    seg_of = 7'b0111111;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] an_of(input int slot);
    case (slot)
      0:       an_of = 8'hFE;
      1:       an_of = 8'hFD;
      2:       an_of = 8'hFB;
      3:       an_of = 8'hF7;
      4:       an_of = 8'hEF;
      5:       an_of = 8'hDF;
      default: an_of = 8'hFF;
    endcase
  endfunction

  function automatic vec_t mk(input int h, input int m, input int s,
                              input int d0, input int d1, input int d2,
                              input int d3, input int d4, input int d5);
    vec_t v;
    v.h = h; v.m = m; v.s = s;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.d[3] = d3; v.d[4] = d4; v.d[5] = d5;
    return v;
  endfunction

  task automatic setin(input int h, input int m, input int s);
    hour_in = 5'(h);
    min_in  = 6'(m);
    sec_in  = 6'(s);
  endtask

  task automatic push(input int n, input int slot, input int digit, input string tag);
    exp_t e;
    e.n   = n;
    e.an  = an_of(slot);
    e.seg = seg_of(digit);
    e.dp  = !(slot == 2 || slot == 4);
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic at(input int n);
    int g;
    g = 0;
    while (cyc != n) begin
      @(negedge clk_100MHz);
      g++;
      if (g > 3000) begin
        n_chk++;
        $display("FAIL timeout: cycle %0d never reached (cyc=%0d)", n, cyc);
        return;
      end
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      at(e.n);
      n_chk++;
      if ({an, seg, dp} === {e.an, e.seg, e.dp}) n_pass++;
      else $display("FAIL %s cyc=%0d: got an=%h seg=%b dp=%b, want an=%h seg=%b dp=%b",
                    e.tag, cyc, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  initial begin
    int f;
    int c;
    // digits listed as sec ones, sec tens, min ones, min tens, hour ones, hour tens
    vecs[0] = mk(13,  7, 45, 5, 4, 7, 0, 3, 1);
    vecs[1] = mk(23, 59, 59, 9, 5, 9, 5, 3, 2);
    vecs[2] = mk(30,  0,  0, 0, 0, 0, 0, DASH, DASH);
    vecs[3] = mk( 9, 60,  8, 8, 0, DASH, DASH, 9, 0);
    vecs[4] = mk( 0,  0, 63, DASH, DASH, 0, 0, 0, 0);
    vecs[5] = mk(10, 30,  0, 0, 0, 0, 3, 0, 1);

    setin(13, 7, 45);
    reset = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    push(0, 0, 0, "reset_state");
    drain();
    reset = 1'b0;

    // 13:07:45 captured on the first edge, committed on edge 10, visible from cycle 11.
    push(2, 0, 0, "first_s1_before_commit");
    push(10, 2, 0, "first_m1_before_commit");
    push(11, 2, 7, "first_m1_after_commit");
    push(14, 3, 0, "first_m10");
    push(18, 4, 3, "first_h1");
    push(22, 5, 1, "first_h10");
    drain();

    f = 1;
    for (int v = 0; v < 6; v++) begin
      at(FR * f + 12);
      setin(vecs[v].h, vecs[v].m, vecs[v].s);
      for (int i = 0; i < 6; i++)
        push(FR * (f + 2) + DIV * i + 2, i, vecs[v].d[i], $sformatf("vec%0d_slot%0d", v, i));
      drain();
      f += 3;
    end

    // 23:59:59 after 10:30:00: capture at frame+1, commit 17 edges after the frame start edge.
    at(FR * f + 12);
    setin(23, 59, 59);
    c = FR * (f + 1) + 17;
    push(c, 4, 0, "latency_before_commit");
    push(c + 1, 4, 3, "latency_after_commit");
    drain();
    f += 2;

    // Input change mid-frame is invisible until the next capture/commit.
    at(FR * f + 12);
    setin(12, 0, 0);
    at(FR * (f + 2) + 13);
    setin(12, 0, 1);
    push(FR * (f + 2) + 14, 3, 0, "chg_mid_m10");
    push(FR * (f + 3) + 2, 0, 0, "chg_hold_s1");
    push(FR * (f + 4) + 2, 0, 1, "chg_new_s1");
    drain();
    f += 5;

    // Reset while converting minutes (edge 7 of the frame).
    at(FR * f + 12);
    setin(23, 59, 59);
    push(FR * (f + 2) + 6, 1, 5, "pre_reset_s10");
    drain();
    reset = 1'b1;
    @(negedge clk_100MHz);
    push(0, 0, 0, "reset_mid_conv");
    drain();
    reset = 1'b0;
    push(2, 0, 0, "post_reset_no_partial");
    push(17, 4, 0, "post_reset_before_commit");
    push(18, 4, 3, "post_reset_after_commit");
    push(22, 5, 2, "post_reset_h10");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
